cpu_wb_scheduler: RTL and testbench
===================================

Name: cpu_wb_scheduler

Overview:
- Schedules the single register-file write port between the pipeline result (ALU or multiplier, from p4) and load results returning from the readpath.
- Loads are buffered in a small FIFO. They drain into free slots, meaning cycles where the p4 destination is x0.
- A starvation counter forces a drain by stalling p4 when free slots do not appear.
- Sits between the ALU/readpath and the register file. The register file has a registered input, so the p5u_* outputs must be valid before the clock edge.

Parameters:
- MEM_FIFO_DEPTH, 4, number of buffered load results; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go without a pop before a drain is forced; minimum 1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- p4_op  input  6  operation in p4
- p4_dest  input  5  p4 destination register
- p4_dest_zero  input  1  p4 destination is x0; the write slot is free
- p4_alu_result  input  32  ALU result
- p4_mult_result  input  32  multiplier result
- p4_stall  output  1  hold p4 this cycle; its write is deferred
- mem_valid  input  1  load result offered
- mem_ready  output  1  scheduler accepts the load result
- mem_dest  input  5  load destination register
- mem_result  input  32  load data
- p5u_write  output  1  register-file write enable (pre-edge)
- p5u_dest_reg  output  5  write destination (pre-edge)
- p5u_result  output  32  write data (pre-edge); also the bypass source
- p5_result  output  32  p5u_result registered

Behaviour:
- State: FIFO storing {dest[4:0], data[31:0]} with rd_ptr/wr_ptr/count, and starve_cnt (saturating at STARVE_LIMIT).
- On reset low at a clock edge:
  - count, pointers and starve_cnt are cleared, and p5_result is set to 0.
  - Buffered loads are discarded; the pipeline is reset together with this block.
- Outputs during reset follow the combinational rules with an empty FIFO: mem_ready=1, p4_stall=0.
- force_drain = (count!=0) && (starve_cnt==STARVE_LIMIT). It depends on registers only, so there is no combinational loop to p4_stall.
- Port selection, in priority order; all outputs are combinational:
  1. p4_dest_zero=1 and count!=0: write the FIFO head and pop.
  2. p4_dest_zero=1 and count==0: no write (p5u_write=0, p5u_dest_reg=0, p5u_result=0), unless the bypass applies (see Optional Feature).
  3. p4_dest_zero=0 and force_drain: write the FIFO head, pop, p4_stall=1.
  4. Otherwise: write p4_dest, with p4_mult_result if p4_op==`OP_MUL, else p4_alu_result.
- p4_stall is 0 in every case except case 3.
- A stalled p4 instruction presents the same inputs next cycle. Since starve_cnt is then 0, it writes next cycle.
- mem_ready = (count != MEM_FIFO_DEPTH). A push occurs when mem_valid && mem_ready and the load is not bypassed.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pushing into an empty FIFO: the earliest write of that entry is the next cycle.
- When full: mem_ready=0. A pop in that cycle frees an entry, but mem_ready rises only on the next cycle.
- Pointers wrap modulo MEM_FIFO_DEPTH.
- starve_cnt:
  - cleared when count==0 or a pop occurs;
  - otherwise incremented, saturating at STARVE_LIMIT;
  - evaluated on the pre-push count, so a just-pushed entry starts counting from 0.
- Writes to x0 from the FIFO (mem_dest=0) are performed as normal writes; the register file ignores them.
- p5_result <= p5u_result every cycle, with no enable.
- FIFO ordering is strict: loads are written in arrival order.

Optional Feature:
- Macro: CPU_WB_MEM_BYPASS_EN.
- Defined: in case 2, if mem_valid=1, the load is written in the same cycle (p5u_write=1, p5u_dest_reg=mem_dest, p5u_result=mem_result). It is not pushed, and mem_ready=1.
- Undefined: case 2 never writes. Every load goes through the FIFO, giving at least 1 cycle of latency.

Test Plan:
- Reset low 2 cycles with mem_valid=0, release -> mem_ready=1, p4_stall=0, p5_result=0; p4_dest=5, alu_result=0x11 -> p5u_write=1, p5u_dest_reg=5, p5u_result=0x11; p5_result=0x11 on the next cycle.
- p4_op=`OP_MUL, p4_dest=3, mult_result=0xDEAD, alu_result=0x1 -> p5u_result=0xDEAD.
- Bypass undefined: load {7, 0xCAFE} while p4_dest_zero=1 and FIFO empty -> pushed; next cycle with p4_dest_zero=1 -> write r7=0xCAFE, count returns to 0. Bypass defined: same stimulus -> write r7=0xCAFE in the same cycle, count stays 0.
- FIFO holds 1 entry and p4_dest_zero=0 for 10 cycles (STARVE_LIMIT=8) -> after 8 non-pop cycles, cycle 9 has p4_stall=1 and writes the FIFO entry; cycle 10 writes the held p4 result.
- Push 5 loads with p4_dest_zero=0 throughout (DEPTH=4) -> mem_ready=0 after 4 accepted; the 5th is held with mem_valid=1 until the forced drain; all 5 loads are written in arrival order.
- Assert reset with 3 entries buffered -> count=0, no buffered load is written after release, mem_ready=1.

Source files
------------

// File: rtl/cpu_wb_scheduler.sv
// cpu_wb_scheduler: arbitrates the single register-file write port between
// the p4 pipeline result and load results returning from the readpath.
// Loads wait in a small FIFO and drain into free slots, which are cycles
// whose p4 destination is x0. A starvation counter stalls p4 to force a
// drain when free slots stop appearing.
// Optional feature: define CPU_WB_MEM_BYPASS_EN to write a load in the
// same cycle it arrives if the slot is free and the FIFO is empty.

`ifndef OP_MUL
`define OP_MUL 6'h0C
`endif

module cpu_wb_scheduler #(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  p4_op,
  input  logic [4:0]  p4_dest,
  input  logic        p4_dest_zero,
  input  logic [31:0] p4_alu_result,
  input  logic [31:0] p4_mult_result,
  output logic        p4_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_result,
  output logic        p5u_write,
  output logic [4:0]  p5u_dest_reg,
  output logic [31:0] p5u_result,
  output logic [31:0] p5_result
);

  localparam int PTR_W = $clog2(MEM_FIFO_DEPTH);
  localparam int CNT_W = $clog2(MEM_FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [4:0]       fifo_dest [MEM_FIFO_DEPTH];
  logic [31:0]      fifo_data [MEM_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] eff_count;
  logic [STV_W-1:0] starve_cnt;
  logic             force_drain;
  logic             pop;
  logic             push;
  logic             bypass;

  // Write-port selection; while reset is held the FIFO is treated as empty
  // so the outputs are well defined before the first reset edge clears it.
  always_comb begin
    eff_count    = reset ? count : '0;
    force_drain  = (eff_count != '0) && (starve_cnt == LIMIT_C);
    p5u_write    = 1'b0;
    p5u_dest_reg = '0;
    p5u_result   = '0;
    p4_stall     = 1'b0;
    pop          = 1'b0;
    bypass       = 1'b0;
    if (p4_dest_zero) begin
      if (eff_count != '0) begin
        p5u_write    = 1'b1;
        p5u_dest_reg = fifo_dest[rd_ptr];
        p5u_result   = fifo_data[rd_ptr];
        pop          = 1'b1;
      end
`ifdef CPU_WB_MEM_BYPASS_EN
      else if (mem_valid) begin
        p5u_write    = 1'b1;
        p5u_dest_reg = mem_dest;
        p5u_result   = mem_result;
        bypass       = 1'b1;
      end
`endif
    end else if (force_drain) begin
      p5u_write    = 1'b1;
      p5u_dest_reg = fifo_dest[rd_ptr];
      p5u_result   = fifo_data[rd_ptr];
      pop          = 1'b1;
      p4_stall     = 1'b1;
    end else begin
      p5u_write    = 1'b1;
      p5u_dest_reg = p4_dest;
      p5u_result   = (p4_op == `OP_MUL) ? p4_mult_result : p4_alu_result;
    end
    mem_ready = (eff_count != DEPTH_C);
    push      = reset && mem_valid && mem_ready && !bypass;
  end

  // Load storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dest[wr_ptr] <= mem_dest;
      fifo_data[wr_ptr] <= mem_result;
    end
  end

  // Pointers, occupancy, starvation counter and the registered result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      p5_result  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if ((count == '0) || pop) starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + STV_W'(1);
      p5_result <= p5u_result;
    end
  end

endmodule

// File: tb/tb_cpu_wb_scheduler.sv
// tb_cpu_wb_scheduler: directed and randomized stimulus for cpu_wb_scheduler,
// checked every cycle against a queue-based model of the write-port rules.

`ifndef OP_MUL
`define OP_MUL 6'h0C
`endif

module tb_cpu_wb_scheduler;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef CPU_WB_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  p4_op;
  logic [4:0]  p4_dest;
  logic        p4_dest_zero;
  logic [31:0] p4_alu_result;
  logic [31:0] p4_mult_result;
  logic        p4_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        p5u_write;
  logic [4:0]  p5u_dest_reg;
  logic [31:0] p5u_result;
  logic [31:0] p5_result;

  always #5 clock = ~clock;

  cpu_wb_scheduler #(.MEM_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .p4_op(p4_op), .p4_dest(p4_dest),
    .p4_dest_zero(p4_dest_zero), .p4_alu_result(p4_alu_result),
    .p4_mult_result(p4_mult_result), .p4_stall(p4_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest),
    .mem_result(mem_result), .p5u_write(p5u_write),
    .p5u_dest_reg(p5u_dest_reg), .p5u_result(p5u_result),
    .p5_result(p5_result)
  );

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } load_t;

  int          checks = 0;
  int          errors = 0;
  load_t       q[$];
  int          starve = 0;
  logic [31:0] prev_result = '0;
  bit          last_stall = 1'b0;
  bit          last_accept = 1'b0;
  int          obs_stalls = 0;
  int          obs_writes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input logic [5:0] op, input logic [4:0] dest,
                               input bit dz, input logic [31:0] alu, input logic [31:0] mult,
                               input bit mv, input logic [4:0] md, input logic [31:0] mr);
    @(negedge clock);
    reset          = rst;
    p4_op          = op;
    p4_dest        = dest;
    p4_dest_zero   = dz;
    p4_alu_result  = alu;
    p4_mult_result = mult;
    mem_valid      = mv;
    mem_dest       = md;
    mem_result     = mr;
  endtask

  // Evaluate the model for the current inputs, compare, then advance past the edge.
  task automatic runCycle(input string tag);
    int          qs, pre;
    bit          fd, byp, pop_e, stall_e, ready_e, push_e;
    logic        w;
    logic [4:0]  d;
    logic [31:0] r;
    #1;
    qs = reset ? q.size() : 0;
    fd = (qs != 0) && (starve == LIMIT);
    w = 1'b0; d = '0; r = '0; byp = 0; pop_e = 0; stall_e = 0;
    if (p4_dest_zero) begin
      if (qs != 0) begin
        w = 1'b1; d = q[0].dest; r = q[0].data; pop_e = 1;
      end else if (BYP && mem_valid) begin
        w = 1'b1; d = mem_dest; r = mem_result; byp = 1;
      end
    end else if (fd) begin
      w = 1'b1; d = q[0].dest; r = q[0].data; pop_e = 1; stall_e = 1;
    end else begin
      w = 1'b1; d = p4_dest;
      r = (p4_op == `OP_MUL) ? p4_mult_result : p4_alu_result;
    end
    ready_e = (qs != DEPTH);
    push_e  = reset && mem_valid && ready_e && !byp;

    checkOutput({tag, ".write"},  32'(p5u_write),    32'(w));
    checkOutput({tag, ".dest"},   32'(p5u_dest_reg), 32'(d));
    checkOutput({tag, ".result"}, p5u_result,        r);
    checkOutput({tag, ".stall"},  32'(p4_stall),     32'(stall_e));
    checkOutput({tag, ".ready"},  32'(mem_ready),    32'(ready_e));
    checkOutput({tag, ".p5"},     p5_result,         prev_result);

    if (p4_stall === 1'b1) obs_stalls++;
    if (p5u_write === 1'b1) obs_writes++;
    last_stall  = stall_e;
    last_accept = reset && (push_e || byp);

    @(posedge clock);
    if (!reset) begin
      q.delete();
      starve = 0;
      prev_result = '0;
    end else begin
      pre = q.size();
      if (pop_e) void'(q.pop_front());
      if (pre == 0 || pop_e) starve = 0;
      else if (starve < LIMIT) starve++;
      if (push_e) q.push_back({mem_dest, mem_result});
      prev_result = r;
    end
  endtask

  initial begin
    int          stall_at;
    int          loads_done;
    int          base;
    bit          pend;
    logic [5:0]  r_op;
    logic [4:0]  r_dest, r_md;
    logic [31:0] r_alu, r_mult, r_mr;
    bit          r_dz;

    // Reset held for two edges; the first has no p5_result history to check.
    reset = 1'b0; p4_op = '0; p4_dest = '0; p4_dest_zero = 1'b1;
    p4_alu_result = '0; p4_mult_result = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_result = '0;
    @(posedge clock);
    applyStimulus(0, 6'h00, 5'd0, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    runCycle("reset");

    // Plain ALU write and its registered copy.
    applyStimulus(1, 6'h00, 5'd5, 0, 32'h11, 32'h22, 0, 5'd0, 32'h0);
    runCycle("alu");
    #1 checkOutput("alu.p5_next", p5_result, 32'h11);

    // Multiplier result selected by opcode.
    applyStimulus(1, `OP_MUL, 5'd3, 0, 32'h1, 32'hDEAD, 0, 5'd0, 32'h0);
    runCycle("mul");
    #1 checkOutput("mul.p5_next", p5_result, 32'hDEAD);

    // Load arriving in a free slot with an empty FIFO, then a second free slot.
    applyStimulus(1, 6'h00, 5'd0, 1, 32'h0, 32'h0, 1, 5'd7, 32'hCAFE);
    runCycle("load_free0");
    applyStimulus(1, 6'h00, 5'd0, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    runCycle("load_free1");
    checkOutput("load_free.fifo_empty_after", 32'(mem_ready), 32'd1);

    // One buffered entry starved by ten busy slots after its push cycle.
    applyStimulus(1, 6'h00, 5'd4, 0, 32'h44, 32'h0, 1, 5'd9, 32'h99);
    runCycle("starve_push");
    stall_at = 0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 6'h00, 5'd4, 0, 32'h44, 32'h0, 0, 5'd0, 32'h0);
      runCycle("starve");
      if (last_stall && stall_at == 0) stall_at = i;
    end
    checkOutput("starve.stall_cycle", 32'(stall_at), 32'd9);

    // Five loads against continuously busy slots; only forced drains free them.
    base = obs_stalls;
    loads_done = 0;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1, 6'h00, 5'd6, 0, 32'h600 + 32'(i), 32'h0,
                    loads_done < 5, 5'(10 + loads_done), 32'hA000 + 32'(loads_done));
      runCycle("five");
      if (last_accept) loads_done++;
    end
    checkOutput("five.accepted", 32'(loads_done), 32'd5);
    checkOutput("five.forced_drains", 32'(obs_stalls - base), 32'd5);

    // Reset with three buffered loads: none of them may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6'h00, 5'd8, 0, 32'h80, 32'h0, 1, 5'(20 + i), 32'hB000 + 32'(i));
      runCycle("rst_fill");
    end
    applyStimulus(0, 6'h00, 5'd8, 0, 32'h80, 32'h0, 0, 5'd0, 32'h0);
    runCycle("rst_assert");
    base = obs_writes;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 6'h00, 5'd0, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      runCycle("rst_after");
    end
    checkOutput("rst_after.writes", 32'(obs_writes - base), 32'd0);
    checkOutput("rst_after.ready", 32'(mem_ready), 32'd1);

    // Randomized traffic; stalled p4 and unaccepted loads are held steady.
    pend = 0; r_op = '0; r_dest = '0; r_dz = 1; r_alu = '0; r_mult = '0; r_md = '0; r_mr = '0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r_op   = ($urandom_range(0, 3) == 0) ? `OP_MUL : 6'($urandom_range(0, 63));
        r_dz   = ($urandom_range(0, 9) < 3);
        r_dest = r_dz ? 5'd0 : 5'($urandom_range(1, 31));
        r_alu  = $urandom;
        r_mult = $urandom;
      end
      if (!pend) begin
        pend = ($urandom_range(0, 1) == 1);
        r_md = 5'($urandom_range(0, 31));
        r_mr = $urandom;
      end
      applyStimulus($urandom_range(0, 79) != 0, r_op, r_dest, r_dz, r_alu, r_mult, pend, r_md, r_mr);
      runCycle("rand");
      if (last_accept) pend = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
